// File: rtl/mapa_loader_pkg.sv
// mapa_loader_pkg
// Shared constants for the mapa frame loader: display geometry, the
// default blank row pattern (segments are active-low, so all ones = off)
// and the loader FSM state encoding.
package mapa_loader_pkg;

  localparam int ROWS  = 8;
  localparam int WIDTH = 7;
  localparam int ROW_AW = 3;

  localparam logic [WIDTH-1:0] BLANK_DEFAULT = 7'b1111111;

  // Loader FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/mapa_bank.sv
// mapa_bank
// Double-buffered 8x7 row store. Rows are written one at a time into the
// shadow bank; a commit copies all eight shadow rows into the display bank
// in a single edge, so the display never shows a half-loaded frame.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset, both banks -> BLANK
//   we       write enable for the shadow bank
//   waddr    shadow row to write
//   wdata    row pattern to write
//   commit   copy shadow -> display on this edge
//   display  committed rows, row k in display[k]
module mapa_bank
  import mapa_loader_pkg::*;
#(
  parameter logic [WIDTH-1:0] BLANK = BLANK_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [ROW_AW-1:0]           waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        commit,
  output logic [ROWS-1:0][WIDTH-1:0]  display
);

  logic [ROWS-1:0][WIDTH-1:0] shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= {ROWS{BLANK}};
    end else if (we) begin
      shadow[waddr] <= wdata;
    end
  end

  // Commit samples shadow before any same-edge write lands; the loader
  // never writes and commits on the same edge anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display <= {ROWS{BLANK}};
    end else if (commit) begin
      display <= shadow;
    end
  end

endmodule

// File: rtl/mapa_loader.sv
// mapa_loader
// Loads an 8-row display frame beat by beat into a shadow bank, then
// commits all rows to the display outputs at once.
//
// Handshake: a beat transfers on a rising edge where data_valid and
// data_ready are both high. data_ready is combinational: high only in LOAD
// and only while start is low (start restarts the frame and wins over a
// coincident beat). The source holds data_in stable while data_valid is
// high and data_ready is low.
//
// Ports
//   clk, reset            clock / asynchronous active-high reset
//   start                 begin (or restart) a frame; pointer -> row 0
//   data_in, data_valid   row pattern for the current pointer and its valid
//   data_ready            loader accepts data_in this cycle
//   mapa0..mapa7          committed display rows
//   row_idx               next shadow row to be written
//   busy                  FSM is not IDLE
//   frame_done            one-cycle pulse after a commit
//   state_dbg             current FSM state (ST_* encoding)
module mapa_loader
  import mapa_loader_pkg::*;
#(
  parameter logic [WIDTH-1:0] BLANK = BLANK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [WIDTH-1:0]  mapa0,
  output logic [WIDTH-1:0]  mapa1,
  output logic [WIDTH-1:0]  mapa2,
  output logic [WIDTH-1:0]  mapa3,
  output logic [WIDTH-1:0]  mapa4,
  output logic [WIDTH-1:0]  mapa5,
  output logic [WIDTH-1:0]  mapa6,
  output logic [WIDTH-1:0]  mapa7,
  output logic [ROW_AW-1:0] row_idx,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  logic [1:0]                 state;
  logic                       beat;
  logic                       commit;
  logic [ROWS-1:0][WIDTH-1:0] display;

  assign data_ready = (state == ST_LOAD) && !start;
  assign beat       = data_valid && data_ready;
  assign commit     = (state == ST_COMMIT);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            row_idx <= '0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            row_idx <= '0;
          end else if (beat) begin
            // 3-bit pointer wraps 7 -> 0 on the last row
            row_idx <= row_idx + 3'd1;
            if (row_idx == 3'd7) begin
              state <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          // Display bank loads on this same edge; start is ignored here.
          state      <= ST_IDLE;
          frame_done <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          row_idx <= '0;
        end
      endcase
    end
  end

  mapa_bank #(
    .BLANK(BLANK)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (beat),
    .waddr   (row_idx),
    .wdata   (data_in),
    .commit  (commit),
    .display (display)
  );

  assign mapa0 = display[0];
  assign mapa1 = display[1];
  assign mapa2 = display[2];
  assign mapa3 = display[3];
  assign mapa4 = display[4];
  assign mapa5 = display[5];
  assign mapa6 = display[6];
  assign mapa7 = display[7];

endmodule
